store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 175 +++++++++++++++++
 tb/tb_store_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store FIFO between MEM and the unified memory write port.
// Optional STORE_FWD_EN forwards an exact-match pending store to a load.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_funct3,
    output logic             st_ready,
    output logic             st_err,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_funct3,
    output logic             ld_stall,
    output logic             fwd_valid,
    output logic [31:0]      fwd_data,
    input  logic             mem_busy,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [2:0]       mem_funct3,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [1:0]       e_size [DEPTH];
    logic [DEPTH-1:0] e_vld;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic             full;
    logic             st_legal;
    logic             push;
    logic             pop;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign st_legal = (st_funct3 == 3'b000) ||
                      (st_funct3 == 3'b001) ||
                      (st_funct3 == 3'b010);

    // Full rejects a push even when the head drains in the same cycle.
    assign push     = st_valid && !full && st_legal && !rst;
    assign st_ready = push;
    assign pop      = !empty && !mem_busy && !rst;

    assign mem_we     = pop;
    assign mem_addr   = e_addr[head];
    assign mem_wdata  = e_data[head];
    assign mem_funct3 = {1'b0, e_size[head]};

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            e_vld  <= '0;
            st_err <= 1'b0;
        end else begin
            st_err <= st_valid && !st_legal;
            if (push) begin
                e_vld[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                e_vld[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= st_addr;
            e_data[tail] <= st_data;
            e_size[tail] <= st_funct3[1:0];
        end
    end

    function automatic logic [32:0] span(input logic [1:0] sz);
        unique case (sz)
            2'b00:   span = 33'd0;
            2'b01:   span = 33'd1;
            default: span = 33'd3;
        endcase
    endfunction

    logic [32:0]      ld_lo;
    logic [32:0]      ld_hi;
    logic [DEPTH-1:0] ov;
    logic             any_ov;

    assign ld_lo = {1'b0, ld_addr};
    assign ld_hi = ld_lo + span(ld_funct3[1:0]);

    // 33-bit compare so a range ending at 0xFFFFFFFF never wraps.
    always_comb begin
        ov = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ov[i] = e_vld[i] &&
                    ({1'b0, e_addr[i]} <= ld_hi) &&
                    (ld_lo <= {1'b0, e_addr[i]} + span(e_size[i]));
        end
    end

    assign any_ov = |ov;

`ifdef STORE_FWD_EN
    logic             one_hit;
    logic [PTR_W-1:0] sel;
    logic [1:0]       ld_sz;
    logic             fwd_ok;
    logic             fwd_hit;
    logic [31:0]      src;
    logic [31:0]      ext;

    assign one_hit = any_ov && ((ov & (ov - DEPTH'(1))) == '0);
    assign ld_sz   = (ld_funct3[1:0] == 2'b11) ? 2'b10 : ld_funct3[1:0];

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ov[i]) sel = PTR_W'(i);
        end
    end

    assign fwd_ok = one_hit &&
                    (e_addr[sel] == ld_addr) &&
                    (e_size[sel] >= ld_sz);
    assign src    = e_data[sel];

    always_comb begin
        unique case (ld_funct3)
            3'b000:  ext = {{24{src[7]}}, src[7:0]};
            3'b001:  ext = {{16{src[15]}}, src[15:0]};
            3'b100:  ext = {24'd0, src[7:0]};
            3'b101:  ext = {16'd0, src[15:0]};
            default: ext = src;
        endcase
    end

    assign fwd_hit   = ld_valid && !st_valid && !rst && fwd_ok;
    assign fwd_valid = fwd_hit;
    assign fwd_data  = fwd_hit ? ext : 32'd0;
`else
    logic fwd_ok;
    logic unused_ld_sign;

    assign fwd_ok         = 1'b0;
    assign unused_ld_sign = ld_funct3[2];
    assign fwd_valid      = 1'b0;
    assign fwd_data       = 32'd0;
`endif

    // A load racing a new store always yields so FIFO order is kept.
    assign ld_stall = ld_valid && !rst &&
                      (st_valid || (any_ov && !fwd_ok));

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Expectations adapt to STORE_FWD_EN when it is defined.
module tb_store_buffer;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_stall;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        mem_busy;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_funct3(st_funct3), .st_ready(st_ready), .st_err(st_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_stall(ld_stall), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
    endtask

    task automatic set_ld(input logic v, input logic [31:0] a,
                          input logic [2:0] f);
        ld_valid  = v;
        ld_addr   = a;
        ld_funct3 = f;
    endtask

    initial begin
        rst      = 1'b1;
        mem_busy = 1'b0;
        set_st(0, 0, 0, 0);
        set_ld(0, 0, 0);
        tick();
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_we", 32'(mem_we), 0);
        check("rst_err", 32'(st_err), 0);
        rst = 1'b0;

        // single SW drains the next cycle
        set_st(1, 907, 32'h22, 3'b010);
        #1 check("t1_ready", 32'(st_ready), 1);
        tick();
        set_st(0, 0, 0, 0);
        #1;
        check("t1_we", 32'(mem_we), 1);
        check("t1_addr", mem_addr, 907);
        check("t1_wdata", mem_wdata, 32'h22);
        check("t1_f3", 32'(mem_funct3), 2);
        check("t1_cnt1", 32'(count), 1);
        tick();
        check("t1_cnt0", 32'(count), 0);
        check("t1_empty", 32'(empty), 1);
        check("t1_we0", 32'(mem_we), 0);

        // fill to full, then drain in order
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_st(1, 32'(4 * i), 32'(i + 'h100), 3'b010);
            #1 check($sformatf("t2_ready%0d", i), 32'(st_ready),
                     (i < 4) ? 1 : 0);
            tick();
        end
        set_st(0, 0, 0, 0);
        #1 check("t2_cnt4", 32'(count), 4);
        mem_busy = 1'b0;
        set_st(1, 200, 32'h55, 3'b010);
        #1;
        check("t2_full_pop", 32'(st_ready), 0);
        check("t2_we0", 32'(mem_we), 1);
        check("t2_addr0", mem_addr, 0);
        tick();
        set_st(0, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            #1;
            check($sformatf("t2_we%0d", i), 32'(mem_we), 1);
            check($sformatf("t2_addr%0d", i), mem_addr, 32'(4 * i));
            check($sformatf("t2_data%0d", i), mem_wdata, 32'(i + 'h100));
            tick();
        end
        check("t2_empty", 32'(empty), 1);
        check("t2_we_end", 32'(mem_we), 0);

        // exact-size overlap: stall or forward
        mem_busy = 1'b1;
        set_st(1, 907, 32'h22, 3'b010);
        tick();
        set_st(0, 0, 0, 0);
        set_ld(1, 907, 3'b010);
        #1;
        check("t3_stall", 32'(ld_stall), FWD ? 0 : 1);
        check("t3_fv", 32'(fwd_valid), FWD ? 1 : 0);
        check("t3_fd", fwd_data, FWD ? 32'h22 : 0);
        mem_busy = 1'b0;
        #1;
        check("t3_we", 32'(mem_we), 1);
        check("t3_stall_drain", 32'(ld_stall), FWD ? 0 : 1);
        tick();
        check("t3_stall_clr", 32'(ld_stall), 0);
        check("t3_fv_clr", 32'(fwd_valid), 0);
        check("t3_empty", 32'(empty), 1);
        set_st(1, 600, 32'h5, 3'b010);
        set_ld(1, 500, 3'b010);
        #1 check("t3_st_wins", 32'(ld_stall), 1);
        tick();
        set_st(0, 0, 0, 0);
        #1 check("t3_no_ov", 32'(ld_stall), 0);
        tick();
        set_ld(0, 0, 0);

        // sub-word forwarding / partial overlap
        mem_busy = 1'b1;
        set_st(1, 100, 32'h0000_00F0, 3'b010);
        tick();
        set_st(0, 0, 0, 0);
        set_ld(1, 100, 3'b000);
        #1;
        check("t4_lb_stall", 32'(ld_stall), FWD ? 0 : 1);
        check("t4_lb_fv", 32'(fwd_valid), FWD ? 1 : 0);
        check("t4_lb_fd", fwd_data, FWD ? 32'hFFFF_FFF0 : 0);
        set_ld(1, 100, 3'b100);
        #1 check("t4_lbu_fd", fwd_data, FWD ? 32'h0000_00F0 : 0);
        set_ld(1, 101, 3'b001);
        #1;
        check("t4_lh_stall", 32'(ld_stall), 1);
        check("t4_lh_fv", 32'(fwd_valid), 0);
        set_ld(0, 0, 0);
        mem_busy = 1'b0;
        tick();
        check("t4_empty", 32'(empty), 1);

        // byte-range edges, then reset mid-flight
        mem_busy = 1'b1;
        set_st(1, 100, 32'hAB, 3'b000);
        tick();
        set_st(0, 0, 0, 0);
        set_ld(1, 104, 3'b010);
        #1;
        check("t5_sb_stall", 32'(ld_stall), 0);
        check("t5_sb_fv", 32'(fwd_valid), 0);
        set_ld(0, 0, 0);
        set_st(1, 103, 32'h1234, 3'b001);
        tick();
        set_st(0, 0, 0, 0);
        set_ld(1, 104, 3'b010);
        #1 check("t5_sh_stall", 32'(ld_stall), 1);
        set_ld(1, 102, 3'b000);
        #1 check("t5_gap", 32'(ld_stall), 0);
        set_ld(0, 0, 0);
        set_st(1, 300, 32'h7, 3'b010);
        tick();
        set_st(0, 0, 0, 0);
        #1 check("t6_cnt3", 32'(count), 3);
        rst      = 1'b1;
        mem_busy = 1'b0;
        set_ld(1, 100, 3'b010);
        set_st(1, 400, 32'h9, 3'b010);
        #1;
        check("t6_rst_we", 32'(mem_we), 0);
        check("t6_rst_stall", 32'(ld_stall), 0);
        check("t6_rst_fv", 32'(fwd_valid), 0);
        tick();
        rst = 1'b0;
        set_st(0, 0, 0, 0);
        set_ld(0, 0, 0);
        #1;
        check("t6_cnt0", 32'(count), 0);
        check("t6_empty", 32'(empty), 1);
        check("t6_we0", 32'(mem_we), 0);
        tick();
        check("t6_we0b", 32'(mem_we), 0);

        // illegal store funct3
        set_st(1, 0, 32'h1, 3'b011);
        #1 check("t6_ill_ready", 32'(st_ready), 0);
        tick();
        set_st(0, 0, 0, 0);
        #1;
        check("t6_err1", 32'(st_err), 1);
        check("t6_ill_cnt", 32'(count), 0);
        tick();
        check("t6_err0", 32'(st_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
